// File: rtl/uart_rx_byte_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling constants and the
// baud divider computation, which the transmitter will also use.
package uart_rx_byte_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    // Sample-tick divider, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_byte_baud_tick.sv
// Oversampling tick generator: a 1-cycle enable every DIV clocks. A synchronous
// clear restarts the period so ticks can be phase-aligned to a line edge.
module uart_baud_tick #(
    parameter int DIV = 78
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = 1'b0;
        cnt_d  = cnt_q - CW'(1);
        if (clr_i) begin
            cnt_d = CW'(DIV - 1);
        end else if (cnt_q == '0) begin
            tick_o = 1'b1;
            cnt_d  = CW'(DIV - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with x16 oversampling and a one-byte valid/ready holding register.
// Define UART_RX_MAJORITY_EN to vote each bit from samples at ticks 7, 8 and 9.
//
// state      | meaning
// IDLE       | line idle, waiting for a falling edge
// START      | checking the start bit at mid-bit
// DATA       | sampling 8 data bits, LSB first
// STOP       | checking the stop bit, delivering the byte
// WAIT_IDLE  | framing error seen, waiting for the line to return high
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int clock_frequency = 12000000,
    parameter int uart_baud_rate  = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int DIV = baud_div(clock_frequency, uart_baud_rate);

    rx_state_e  state_q, state_d;
    logic       rx_meta_q, rxs_q, rxs_prev_q;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic       valid_q, valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic       s8_q, baud_clr, baud_tick, at_t8, decide, bit_val;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (baud_clr),
        .tick_o (baud_tick)
    );

    // The decision is taken at tick 9 in both builds so latency does not depend on voting.
    assign at_t8  = baud_tick && (tick_cnt_q == 4'(MID_TICK - 1));
    assign decide = baud_tick && (tick_cnt_q == 4'(MID_TICK));

`ifdef UART_RX_MAJORITY_EN
    logic s7_q;
    logic at_t7;
    assign at_t7   = baud_tick && (tick_cnt_q == 4'(MID_TICK - 2));
    assign bit_val = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     s7_q <= 1'b1;
        else if (at_t7) s7_q <= rxs_q;
    end
`else
    assign bit_val = s8_q;
`endif

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        baud_clr    = 1'b0;

        if (baud_tick) tick_cnt_d = tick_cnt_q + 4'd1;
        if (valid_q && ready) valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d    = ST_START;
                    baud_clr   = 1'b1;
                    tick_cnt_d = 4'd0;
                end
            end
            ST_START: begin
                if (decide) begin
                    state_d   = bit_val ? ST_IDLE : ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d   = {bit_val, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (bit_val) begin
                        state_d = ST_IDLE;
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            s8_q        <= 1'b1;
            state_q     <= ST_IDLE;
            tick_cnt_q  <= 4'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            rxs_prev_q  <= rxs_q;
            if (at_t8) s8_q <= rxs_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
